// File: rtl/cpu_top_if.sv
// ---------------------------------------------------------------------------
// cpu_top_if -- simple single-cycle memory bus shared by the core and the
// instruction/data memories.
//
//   addr   master -> slave   byte address
//   wdata  master -> slave   full-word write data
//   we     master -> slave   write enable, word lands on the next rising edge
//   rdata  slave  -> master  asynchronous read data for addr
//
// Modports: master (core side), slave (memory side).
// ---------------------------------------------------------------------------
interface cpu_top_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu_top.sv
// ---------------------------------------------------------------------------
// cpu_top -- single-clock simulation SoC: 5-stage MIPS32-subset core
// (openmips), asynchronous instruction ROM (rom) and byte-banked data RAM
// (ram). The core has no branches; it issues one instruction per cycle and
// forwards EX and MEM results into ID. LL/SC uses a single llbit held in MEM.
//
// Ports (cpu_top):
//   clk  in  system clock, rising edge
//   rst  in  synchronous, active-high reset
// Parameters: ROM_WORDS, RAM_WORDS (32-bit words).
//
// Optional build macro: MIPS_TRACE_EN -- when defined, every writeback to a
// nonzero register is printed with time, register number and value.
// ---------------------------------------------------------------------------

// Instruction ROM: asynchronous read, word index from pc bits. Contents are
// loaded from outside (hierarchically), never written by the design.
module rom #(
  parameter int WORDS = 1024
) (
  cpu_top_if.slave bus
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] memory [0:WORDS-1];

  assign bus.rdata = memory[bus.addr[AW+1:2]];

  logic unused_bus;
  assign unused_bus = ^{bus.addr[31:AW+2], bus.addr[1:0], bus.wdata, bus.we};
endmodule

// Data RAM: four byte banks, bank0 = bits 7:0 (little-endian). Asynchronous
// read, full-word write on the rising edge. Upper address bits wrap.
module ram #(
  parameter int WORDS = 1024
) (
  input logic      clk,
  cpu_top_if.slave bus
);
  localparam int AW = $clog2(WORDS);

  logic [7:0] bank0 [0:WORDS-1];
  logic [7:0] bank1 [0:WORDS-1];
  logic [7:0] bank2 [0:WORDS-1];
  logic [7:0] bank3 [0:WORDS-1];

  logic [AW-1:0] idx;
  assign idx = bus.addr[AW+1:2];

  assign bus.rdata = {bank3[idx], bank2[idx], bank1[idx], bank0[idx]};

  // NOTE: storage arrays carry no reset; clearing a RAM costs a write port
  // per word and the contents are defined by software anyway.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      bank0[idx] <= bus.wdata[7:0];
      bank1[idx] <= bus.wdata[15:8];
      bank2[idx] <= bus.wdata[23:16];
      bank3[idx] <= bus.wdata[31:24];
    end
  end

  logic unused_bus;
  assign unused_bus = ^{bus.addr[31:AW+2], bus.addr[1:0]};
endmodule

// Register file: $0 hardwired to zero, written in WB, write-through reads so
// an instruction in ID sees the value being retired in the same cycle.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];
endmodule

// Core: IF/ID/EX/MEM/WB, no branches, no load-use interlock.
module openmips (
  input logic       clk,
  input logic       rst,
  cpu_top_if.master ibus,
  cpu_top_if.master dbus
);
  typedef enum logic [1:0] {ALU_ADD, ALU_OR, ALU_AND, ALU_SLL} alu_op_e;
  typedef enum logic [2:0] {MEM_NONE, MEM_LW, MEM_SW, MEM_LL, MEM_SC} mem_op_e;

  typedef struct packed {
    logic        wen;
    logic [4:0]  dest;
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sdata;
    mem_op_e     mem;
  } id_ex_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] sdata;
    mem_op_e     mem;
  } ex_mem_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] data;
  } mem_wb_t;

  logic [31:0] pc;
  logic [31:0] if_id_inst;
  id_ex_t      id_ex, id_next;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        llbit;

  // ---------------- IF ----------------
  assign ibus.addr  = pc;
  assign ibus.wdata = '0;
  assign ibus.we    = 1'b0;

  // ---------------- ID ----------------
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z;
  logic [31:0] rf_rs, rf_rt, rs_val, rt_val;
  logic [31:0] ex_result, mem_result;
  logic        ex_fwd_ok;
  logic        writes;
  logic [4:0]  dest;

  assign opcode = if_id_inst[31:26];
  assign rs     = if_id_inst[25:21];
  assign rt     = if_id_inst[20:16];
  assign rd     = if_id_inst[15:11];
  assign shamt  = if_id_inst[10:6];
  assign funct  = if_id_inst[5:0];
  assign imm    = if_id_inst[15:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'h0000, imm};

  regfile regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rs),
    .rd2 (rf_rt),
    .we  (mem_wb.wen),
    .wa  (mem_wb.dest),
    .wd  (mem_wb.data)
  );

  // Loads and SC only have their result in MEM, so EX may forward ALU
  // results only. A dest of $0 never sets wen, so $0 is never forwarded.
  assign ex_fwd_ok = id_ex.wen && (id_ex.mem == MEM_NONE);
  assign rs_val = (ex_fwd_ok && id_ex.dest == rs)   ? ex_result  :
                  (ex_mem.wen && ex_mem.dest == rs) ? mem_result : rf_rs;
  assign rt_val = (ex_fwd_ok && id_ex.dest == rt)   ? ex_result  :
                  (ex_mem.wen && ex_mem.dest == rt) ? mem_result : rf_rt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    id_next = '0;
    writes  = 1'b0;
    dest    = rt;
    case (opcode)
      6'h00: begin
        dest      = rd;
        id_next.a = rs_val;
        id_next.b = rt_val;
        case (funct)
          6'h21: begin id_next.op = ALU_ADD; writes = 1'b1; end
          6'h24: begin id_next.op = ALU_AND; writes = 1'b1; end
          6'h25: begin id_next.op = ALU_OR;  writes = 1'b1; end
          6'h00: begin
            id_next.op = ALU_SLL;
            id_next.a  = rt_val;
            id_next.b  = {27'd0, shamt};
            writes     = 1'b1;
          end
          default: ;
        endcase
      end
      6'h0D: begin id_next.op = ALU_OR;  id_next.a = rs_val; id_next.b = imm_z; writes = 1'b1; end
      6'h0F: begin id_next.op = ALU_OR;  id_next.a = '0; id_next.b = {imm, 16'h0000}; writes = 1'b1; end
      6'h08,
      6'h09: begin id_next.op = ALU_ADD; id_next.a = rs_val; id_next.b = imm_s; writes = 1'b1; end
      6'h23: begin id_next.a = rs_val; id_next.b = imm_s; id_next.mem = MEM_LW; writes = 1'b1; end
      6'h30: begin id_next.a = rs_val; id_next.b = imm_s; id_next.mem = MEM_LL; writes = 1'b1; end
      6'h2B: begin
        id_next.a = rs_val; id_next.b = imm_s; id_next.sdata = rt_val; id_next.mem = MEM_SW;
      end
      6'h38: begin
        id_next.a = rs_val; id_next.b = imm_s; id_next.sdata = rt_val; id_next.mem = MEM_SC;
        writes = 1'b1;
      end
      default: ;
    endcase
    id_next.wen  = writes && (dest != 5'd0);
    id_next.dest = dest;
  end

  // ---------------- EX ----------------
  always_comb begin
    case (id_ex.op)
      ALU_OR:  ex_result = id_ex.a | id_ex.b;
      ALU_AND: ex_result = id_ex.a & id_ex.b;
      ALU_SLL: ex_result = id_ex.a << id_ex.b[4:0];
      default: ex_result = id_ex.a + id_ex.b;
    endcase
  end

  // ---------------- MEM ----------------
  assign dbus.addr  = ex_mem.res;
  assign dbus.wdata = ex_mem.sdata;
  // Gated by rst so a store whose MEM edge coincides with reset is dropped.
  assign dbus.we    = !rst && ((ex_mem.mem == MEM_SW) || (ex_mem.mem == MEM_SC && llbit));

  always_comb begin
    case (ex_mem.mem)
      MEM_LW, MEM_LL: mem_result = dbus.rdata;
      MEM_SC:         mem_result = {31'd0, llbit};
      default:        mem_result = ex_mem.res;
    endcase
  end

  // ---------------- pipeline registers ----------------
  // NOTE: sequential state uses non-blocking assignments only, so every stage
  // samples the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      if_id_inst <= '0;
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
      llbit      <= 1'b0;
    end else begin
      pc           <= pc + 32'd4;
      if_id_inst   <= ibus.rdata;
      id_ex        <= id_next;
      ex_mem.wen   <= id_ex.wen;
      ex_mem.dest  <= id_ex.dest;
      ex_mem.res   <= ex_result;
      ex_mem.sdata <= id_ex.sdata;
      ex_mem.mem   <= id_ex.mem;
      mem_wb.wen   <= ex_mem.wen;
      mem_wb.dest  <= ex_mem.dest;
      mem_wb.data  <= mem_result;
      if (ex_mem.mem == MEM_LL)      llbit <= 1'b1;
      else if (ex_mem.mem == MEM_SC) llbit <= 1'b0;
    end
  end

`ifdef MIPS_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && mem_wb.wen)
      $display("%0t: r%0d <= %08h", $time, mem_wb.dest, mem_wb.data);
  end
`else
  // Trace disabled: no extra logic.
`endif
endmodule

module cpu_top #(
  parameter int ROM_WORDS = 1024,
  parameter int RAM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  cpu_top_if ibus ();
  cpu_top_if dbus ();

  openmips openmips (
    .clk  (clk),
    .rst  (rst),
    .ibus (ibus),
    .dbus (dbus)
  );

  rom #(.WORDS(ROM_WORDS)) rom (
    .bus (ibus)
  );

  ram #(.WORDS(RAM_WORDS)) ram (
    .clk (clk),
    .bus (dbus)
  );
endmodule

// File: tb/tb_cpu_top.sv
// ---------------------------------------------------------------------------
// tb_cpu_top -- directed programs for cpu_top. Programs are written into
// rom.memory during reset; register and RAM state is observed hierarchically.
// Expected register results are queued when a program is loaded and popped
// as the pipeline retires them.
// ---------------------------------------------------------------------------
module tb_cpu_top;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cpu_top #(.ROM_WORDS(1024), .RAM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst)
  );

  // Mirror of the core's data bus, used to count RAM write cycles.
  cpu_top_if mon ();
  assign mon.addr  = dut.dbus.addr;
  assign mon.wdata = dut.dbus.wdata;
  assign mon.we    = dut.dbus.we;
  assign mon.rdata = dut.dbus.rdata;

  int n_we = 0;
  always @(negedge clk) if (mon.we === 1'b1) n_we++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] ram_word(input int w);
    return {dut.ram.bank3[w], dut.ram.bank2[w], dut.ram.bank1[w], dut.ram.bank0[w]};
  endfunction

  function automatic logic [31:0] reg_val(input int r);
    return dut.openmips.regfile.regs[r];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for an edge and clear the ROM to NOPs.
  task automatic begin_prog();
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 1024; i++) dut.rom.memory[i] = 32'h0;
  endtask

  // One more reset edge, then release: the next rising edge is edge 1.
  task automatic go();
    tick(1);
    rst = 1'b0;
  endtask

  task automatic put(input int k, input logic [31:0] inst);
    dut.rom.memory[k] = inst;
  endtask

  task automatic expect_reg(input string tag, input int r, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.idx = r;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain_regs();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, reg_val(e.idx), e.val);
    end
  endtask

  initial begin
    exp_t e;
    int we_base;

    // ---------------- program A: reset state + LL/SC sequence ----------------
    begin_prog();
    put(0,  enc_i('h0D, 0, 1, 'h1234));   // ori  $1,$0,0x1234
    put(1,  enc_i('h2B, 0, 1, 0));        // sw   $1,0($0)
    put(2,  enc_i('h0D, 0, 1, 'h5678));   // ori  $1,$0,0x5678
    put(3,  enc_i('h38, 0, 1, 0));        // sc   $1,0($0)  (llbit clear: fails)
    put(4,  enc_i('h23, 0, 1, 0));        // lw   $1,0($0)
    put(5,  32'h0);                       // nop
    put(6,  enc_i('h0D, 0, 1, 0));        // ori  $1,$0,0
    put(7,  enc_i('h30, 0, 1, 0));        // ll   $1,0($0)
    put(8,  32'h0);                       // nop
    put(9,  enc_i('h08, 1, 1, 1));        // addi $1,$1,1
    put(10, enc_i('h38, 0, 1, 0));        // sc   $1,0($0)  (succeeds)
    put(11, enc_i('h23, 0, 1, 0));        // lw   $1,0($0)
    expect_reg("a_e5",  1, 32'h1234);
    expect_reg("a_e6",  1, 32'h1234);
    expect_reg("a_e7",  1, 32'h5678);
    expect_reg("a_e8",  1, 32'h0);
    expect_reg("a_e9",  1, 32'h1234);
    expect_reg("a_e10", 1, 32'h1234);
    expect_reg("a_e11", 1, 32'h0);
    expect_reg("a_e12", 1, 32'h1234);
    expect_reg("a_e13", 1, 32'h1234);
    expect_reg("a_e14", 1, 32'h1235);
    expect_reg("a_e15", 1, 32'h1);
    expect_reg("a_e16", 1, 32'h1235);
    go();

    check("rst_pc",    dut.openmips.pc, 32'h0);
    check("rst_r1",    reg_val(1),  32'h0);
    check("rst_r31",   reg_val(31), 32'h0);
    check("rst_we",    {31'd0, mon.we}, 32'h0);
    we_base = n_we;

    for (int edge_n = 1; edge_n <= 16; edge_n++) begin
      tick(1);
      if (edge_n == 7) check("a_sc_fail_ram", ram_word(0), 32'h1234);
      if (edge_n >= 5) begin
        if (sb.size() == 0) begin
          check("a_sb_empty", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check(e.tag, reg_val(e.idx), e.val);
        end
      end
    end
    check("a_ram_final", ram_word(0), 32'h1235);
    check("a_we_count",  n_we - we_base, 2);

    // ---------------- program B: ALU ops, forwarding, byte lanes ----------------
    begin_prog();
    put(0,  enc_i('h0D, 0, 2, 5));             // ori   $2,$0,5
    put(1,  enc_i('h09, 2, 2, 3));             // addiu $2,$2,3
    put(2,  enc_r(2, 2, 3, 0, 'h21));          // addu  $3,$2,$2
    put(3,  enc_i('h0F, 0, 4, 'hAABB));        // lui   $4,0xAABB
    put(4,  enc_i('h0D, 4, 4, 'hCCDD));        // ori   $4,$4,0xCCDD
    put(5,  enc_i('h2B, 0, 4, 8));             // sw    $4,8($0)
    put(6,  enc_r(4, 3, 5, 0, 'h24));          // and   $5,$4,$3
    put(7,  enc_r(0, 2, 6, 4, 'h00));          // sll   $6,$2,4
    put(8,  enc_i('h08, 0, 7, 'hFFFF));        // addi  $7,$0,-1
    put(9,  enc_i('h0D, 0, 8, 'hFFFF));        // ori   $8,$0,0xFFFF
    put(10, enc_i('h0D, 0, 0, 7));             // ori   $0,$0,7
    put(11, 32'hFC4900FF);                     // unsupported opcode
    put(12, enc_i('h23, 0, 10, 8));            // lw    $10,8($0)
    put(13, 32'h0);                            // nop
    put(14, enc_r(10, 0, 11, 0, 'h21));        // addu  $11,$10,$0
    put(15, enc_i('h23, 0, 12, 'h1008));       // lw    $12,0x1008($0)  (wraps)
    put(16, enc_i('h23, 0, 13, 'hB));          // lw    $13,0xB($0)     (low bits ignored)
    expect_reg("b_addiu_fwd", 2,  32'h8);
    expect_reg("b_addu_fwd",  3,  32'h10);
    expect_reg("b_lui_ori",   4,  32'hAABBCCDD);
    expect_reg("b_and",       5,  32'h10);
    expect_reg("b_sll",       6,  32'h80);
    expect_reg("b_addi_neg",  7,  32'hFFFFFFFF);
    expect_reg("b_ori_zext",  8,  32'h0000FFFF);
    expect_reg("b_r0",        0,  32'h0);
    expect_reg("b_bad_op",    9,  32'h0);
    expect_reg("b_lw",        10, 32'hAABBCCDD);
    expect_reg("b_load_fwd",  11, 32'hAABBCCDD);
    expect_reg("b_wrap",      12, 32'hAABBCCDD);
    expect_reg("b_lowbits",   13, 32'hAABBCCDD);
    go();
    tick(21);
    drain_regs();
    check("b_bank0", {24'd0, dut.ram.bank0[2]}, 32'hDD);
    check("b_bank1", {24'd0, dut.ram.bank1[2]}, 32'hCC);
    check("b_bank2", {24'd0, dut.ram.bank2[2]}, 32'hBB);
    check("b_bank3", {24'd0, dut.ram.bank3[2]}, 32'hAA);

    // ---------------- setup for program C: preset RAM words 0,1,3,4 ----------------
    begin_prog();
    put(0, enc_i('h0F, 0, 1, 'h00C0));   // lui $1,0x00C0
    put(1, enc_i('h0D, 1, 1, 'hFFEE));   // ori $1,$1,0xFFEE
    put(2, enc_i('h2B, 0, 1, 0));        // sw  $1,0($0)
    put(3, enc_i('h0D, 0, 2, 'h55));     // ori $2,$0,0x55
    put(4, enc_i('h2B, 0, 2, 4));        // sw  $2,4($0)
    put(5, enc_i('h0D, 0, 3, 'h33));     // ori $3,$0,0x33
    put(6, enc_i('h2B, 0, 3, 12));       // sw  $3,12($0)
    put(7, enc_i('h0D, 0, 4, 'h44));     // ori $4,$0,0x44
    put(8, enc_i('h2B, 0, 4, 16));       // sw  $4,16($0)
    go();
    tick(14);
    check("s_word0", ram_word(0), 32'h00C0FFEE);
    check("s_word4", ram_word(4), 32'h44);

    // ---------------- program C: reset asserted mid-program ----------------
    begin_prog();
    put(0, enc_i('h38, 0, 9, 4));        // sc  $9,4($0)
    put(1, enc_i('h0F, 0, 12, 'hDEAD));  // lui $12,0xDEAD
    put(2, enc_i('h30, 0, 11, 0));       // ll  $11,0($0)   sets llbit on edge 6
    put(3, enc_i('h2B, 0, 12, 12));      // sw  $12,12($0)  lands on edge 7
    put(4, enc_i('h0D, 0, 10, 'h77));    // ori $10,$0,0x77 would retire on edge 9
    put(5, enc_i('h2B, 0, 12, 16));      // sw  $12,16($0)  MEM edge 9 = reset edge
    go();
    tick(5);
    check("c_sc_first", reg_val(9), 32'h0);
    tick(2);
    check("c_ll",       reg_val(11), 32'h00C0FFEE);
    check("c_sw_ok",    ram_word(3), 32'hDEAD0000);
    tick(1);
    rst = 1'b1;                          // sampled on edge 9
    tick(1);
    rst = 1'b0;
    check("c_rst_pc",   dut.openmips.pc, 32'h0);
    check("c_rst_wb",   reg_val(10), 32'h0);
    check("c_rst_r11",  reg_val(11), 32'h0);
    check("c_rst_sw",   ram_word(4), 32'h44);
    tick(5);
    check("c_sc_after_rst", reg_val(9), 32'h0);
    check("c_sc_no_store",  ram_word(1), 32'h55);
    tick(4);
    check("c_restart_ori",  reg_val(10), 32'h77);
    check("c_restart_sw",   ram_word(4), 32'hDEAD0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_top.md
# cpu_top

Top-level of a single-clock simulation SoC. It integrates three sub-blocks:
- a 5-stage pipelined MIPS32 subset core, `openmips`;
- an instruction ROM, `rom`;
- a byte-banked data RAM, `ram`.

The subset includes LL/SC. The block has no functional I/O besides clock and reset. Benches preload `rom.memory` and observe `openmips.regfile.regs[]` and `ram.bank0..bank3[]` hierarchically, so these instance and array names are fixed.

## Interface
- `ROM_WORDS`, 1024: instruction ROM depth (32-bit words).
- `RAM_WORDS`, 1024: data RAM depth (words; each bank is `RAM_WORDS` bytes).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- Instance `rom`: array `memory[0:ROM_WORDS-1]` of 32 bits.
- Instance `ram`: arrays `bank0..bank3[0:RAM_WORDS-1]` of 8 bits. `bank0` holds bits 7:0 and `bank3` holds bits 31:24 (little-endian).
- Instance `openmips`, containing `regfile` with `regs[0:31]` of 32 bits.

## Operation
- Pipeline is IF/ID/EX/MEM/WB, one instruction issued per cycle, no branches.
- Address mapping:
  - ROM: asynchronous read, word index = `pc[log2(ROM_WORDS)+1:2]`.
  - RAM: word index = `addr[log2(RAM_WORDS)+1:2]`; bits 1:0 are ignored; out-of-range upper bits wrap.
- Supported opcodes:
  - `ori` 0x0D: zero-extended immediate.
  - `lui` 0x0F.
  - `addi` 0x08 and `addiu` 0x09: sign-extended immediate, no overflow trap, identical behaviour.
  - `lw` 0x23, `sw` 0x2B, `ll` 0x30, `sc` 0x38: address = rs + sign-extended immediate.
  - SPECIAL funct `addu` 0x21, `and` 0x24, `or` 0x25, `sll` 0x00 (`sll $0,$0,0` is the NOP).
  - Any other encoding executes as a NOP.
- Register file:
  - `$0` reads as 0 and writes to it are ignored.
  - Written on the rising edge in WB.
  - A read in the same cycle as a write to that register returns the new value (write-through).
- Forwarding into ID: priority EX result, then MEM result (including load data), then WB/regfile.
- No load-use interlock: the instruction immediately after a load/LL must not consume its result (software inserts one NOP).
- RAM timing: asynchronous read in MEM; full-word write on the rising edge ending MEM.
- LL/SC:
  - Single `llbit` in MEM stage.
  - `ll`: loads the word like `lw` and sets `llbit`.
  - `sc` with `llbit`=1: stores rt, writes 1 to rt, clears `llbit`.
  - `sc` with `llbit`=0: no store, writes 0 to rt.
  - Plain `sw` does not affect `llbit`.

## Timing
- Reset values (while `rst`=1 at a rising edge):
  - `pc`=0.
  - All pipeline registers = NOP (no write enables).
  - `llbit`=0.
  - `regs[*]`=0.
- ROM and RAM contents are not reset.
- Retirement timing: the instruction at ROM word k writes its destination register on the (k+5)-th rising edge after the first edge sampling `rst`=0. The value is visible after that edge.
- The store of the instruction at word k lands in RAM on edge k+4.
- Reset asserted mid-program:
  - In-flight instructions are discarded and nothing further is written.
  - A RAM write whose MEM edge coincides with `rst`=1 is suppressed.

## Configuration
- `MIPS_TRACE_EN`:
  - Defined: on every WB register write with a nonzero destination, `$display` the time, register number and value.
  - Undefined: no trace code; functionally identical.

## Test plan
- Reset then `ori $1,$0,0x1234` at word 0 -> `regs[1]`=0x00001234 after edge 5.
- LL/SC sequence, one instruction per cycle (NOP = `sll $0,$0,0`): ori 0x1234; sw 0($0); ori 0x5678; sc 0($0); lw 0($0); NOP; ori $1,$0,0; ll 0($0); NOP; addi $1,$1,1; sc 0($0); lw 0($0).
  - Required `regs[1]`, edges 5..16: 1234, 1234, 5678, 0, 1234, 1234, 0, 1234, 1234, 1235, 1, 1235.
  - Final RAM word 0 = 0x00001235.
- Failed `sc` without prior `ll` -> rt=0 and RAM word unchanged (0x1234 retained).
- Back-to-back dependent ALU ops `ori $2,$0,5`; `addiu $2,$2,3`; `addu $3,$2,$2` -> `regs[3]`=16 (EX/MEM forwarding).
- `sw` of 0xAABBCCDD at address 0x8 -> `bank0[2]`=DD, `bank1[2]`=CC, `bank2[2]`=BB, `bank3[2]`=AA.
- Reset asserted for 1 cycle mid-program -> execution restarts at word 0 and `llbit` is clear (next `sc` returns 0).
